// File: rtl/tx_burst_pkg.sv
// Shared constants, state encoding and saturation helper for the transmit burst engine.
package tx_burst_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int LANES       = 8;
  localparam int DATA_W      = SAMPLE_W * LANES;
  localparam int UNITY_SHIFT = 6;
  localparam logic signed [SAMPLE_W-1:0] PREAMBLE_POS = 16'sd16384;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_PREAMBLE = 2'd1,
    TX_PAYLOAD  = 2'd2,
    TX_GAP      = 2'd3
  } tx_state_e;

  // Clamp a shifted gain product back into the signed 16-bit sample range.
  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [24:0] v);
    if (v > 25'sd32767)
      sat16 = 16'h7fff;
    else if (v < -25'sd32768)
      sat16 = 16'h8000;
    else
      sat16 = v[15:0];
  endfunction
endpackage

// File: rtl/tx_burst_if.sv
// Sample stream from the PS/DMA source into the transmit burst engine.
interface tx_burst_if;
  import tx_burst_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/tx_sample_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers for full/empty.
module tx_sample_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/tx_burst_core.sv
// Transmit burst engine: FIFO-buffered payload, optional fs/2 preamble, gain scaling, zero gap.
// Preamble generation is present only when TX_BURST_PREAMBLE_EN is defined.
//
// state    | meaning
// IDLE     | waiting for burst_start, outputs zero
// PREAMBLE | emitting the fixed +/-16384 alternating-lane pattern
// PAYLOAD  | popping and scaling FIFO words, zeros on underrun
// GAP      | emitting zero guard words before returning to IDLE
module tx_burst_core
  import tx_burst_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int PREAMBLE_WORDS = 4,
  parameter int GAP_WORDS      = 2
) (
  input  logic              clock,
  input  logic              resetn,
  tx_burst_if.slave         s_axis,
  input  logic              burst_start,
  input  logic [7:0]        gain,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              busy,
  output logic              underrun
);
  localparam logic [1:0] ST_IDLE     = TX_IDLE;
  localparam logic [1:0] ST_PREAMBLE = TX_PREAMBLE;
  localparam logic [1:0] ST_PAYLOAD  = TX_PAYLOAD;
  localparam logic [1:0] ST_GAP      = TX_GAP;

  // One down-counter times both the preamble and the gap.
  localparam int TMR_MAX = (PREAMBLE_WORDS > GAP_WORDS) ? PREAMBLE_WORDS : GAP_WORDS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

`ifdef TX_BURST_PREAMBLE_EN
  localparam logic [SAMPLE_W-1:0] PREAMBLE_NEG  = -PREAMBLE_POS;
  localparam logic [DATA_W-1:0]   PREAMBLE_WORD = {(LANES/2){PREAMBLE_NEG, PREAMBLE_POS}};
`endif

  logic [1:0]        state;
  logic [TMR_W-1:0]  tmr;
  logic [7:0]        gain_q;
  logic [DATA_W:0]   fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] scaled;

  assign fifo_pop       = (state == ST_PAYLOAD) && !fifo_empty;
  assign s_axis.s_ready = !fifo_full;
  assign busy           = (state != ST_IDLE);

  tx_sample_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (s_axis.s_valid),
    .wr_data ({s_axis.s_last, s_axis.s_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    scaled = '0;
    for (int k = 0; k < LANES; k++) begin
      logic signed [SAMPLE_W-1:0] samp;
      logic signed [24:0]         prod;
      samp = fifo_rd[k*SAMPLE_W +: SAMPLE_W];
      prod = 25'(samp) * $signed({17'd0, gain_q});
      scaled[k*SAMPLE_W +: SAMPLE_W] = sat16(prod >>> UNITY_SHIFT);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      gain_q    <= '0;
      underrun  <= 1'b0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
    end else begin
      dac_valid <= (state != ST_IDLE);
      dac_data  <= '0;
      case (state)
        ST_IDLE: begin
          if (burst_start) begin
            gain_q   <= gain;
            underrun <= 1'b0;
`ifdef TX_BURST_PREAMBLE_EN
            state    <= ST_PREAMBLE;
            tmr      <= TMR_W'(PREAMBLE_WORDS - 1);
`else
            state    <= ST_PAYLOAD;
`endif
          end
        end
`ifdef TX_BURST_PREAMBLE_EN
        ST_PREAMBLE: begin
          dac_data <= PREAMBLE_WORD;
          if (tmr == '0) state <= ST_PAYLOAD;
          else           tmr   <= tmr - TMR_W'(1);
        end
`else
        ST_PREAMBLE: state <= ST_PAYLOAD;
`endif
        ST_PAYLOAD: begin
          if (fifo_empty) begin
            underrun <= 1'b1;
          end else begin
            dac_data <= scaled;
            if (fifo_rd[DATA_W]) begin
              state <= ST_GAP;
              tmr   <= TMR_W'(GAP_WORDS - 1);
            end
          end
        end
        ST_GAP: begin
          if (tmr == '0) state <= ST_IDLE;
          else           tmr   <= tmr - TMR_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_burst_core.sv
// Self-checking bench for tx_burst_core: directed scenarios plus randomized bursts vs. a reference model.
module tb_tx_burst_core;
  import tx_burst_pkg::*;

`ifdef TX_BURST_PREAMBLE_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 0;
`endif
  localparam int GAP = 2;

  logic         clock = 1'b0;
  logic         resetn;
  logic         burst_start;
  logic [7:0]   gain;
  logic [127:0] dac_data;
  logic         dac_valid;
  logic         busy;
  logic         underrun;

  tx_burst_if s_if ();

  tx_burst_core #(
    .FIFO_DEPTH     (16),
    .PREAMBLE_WORDS (4),
    .GAP_WORDS      (2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .s_axis      (s_if),
    .burst_start (burst_start),
    .gain        (gain),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clock = ~clock;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [128:0] mq[$];
  logic [127:0] exp_q[$];
  logic [127:0] w0, w1, w2;
  logic [7:0]   g;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; a pending stream word is retired if the DUT was ready at that edge.
  task automatic tick();
    logic acc;
    acc = s_if.s_valid && s_if.s_ready;
    @(posedge clock);
    #1;
    if (acc) s_if.s_valid = 1'b0;
  endtask

  function automatic logic [127:0] rand_word();
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[32*k +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [127:0] pre_word();
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[16*k +: 16] = (k % 2 == 0) ? 16'(16384) : 16'(-16384);
    return w;
  endfunction

  // Reference scaling: floor(sample * gain / 64), clamped to the 16-bit range.
  function automatic logic [127:0] scale_ref(input logic [127:0] d, input logic [7:0] gn);
    logic [127:0] w;
    int s, p, r;
    for (int k = 0; k < 8; k++) begin
      s = $signed(d[16*k +: 16]);
      p = s * int'(gn);
      if (p >= 0) r = p / 64;
      else        r = -((-p + 63) / 64);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      w[16*k +: 16] = 16'(r);
    end
    return w;
  endfunction

  task automatic push_word(input logic [127:0] d, input logic l);
    int n;
    n = 0;
    s_if.s_data  = d;
    s_if.s_last  = l;
    s_if.s_valid = 1'b1;
    while (s_if.s_valid && n < 64) begin
      tick();
      n++;
    end
    check("push_accept", 128'(s_if.s_valid), 128'(0));
    s_if.s_valid = 1'b0;
    mq.push_back({l, d});
  endtask

  task automatic build_expected(input logic [7:0] gn);
    logic [128:0] e;
    exp_q.delete();
    for (int i = 0; i < PRE; i++) exp_q.push_back(pre_word());
    while (mq.size() > 0) begin
      e = mq.pop_front();
      exp_q.push_back(scale_ref(e[127:0], gn));
      if (e[128]) break;
    end
    for (int i = 0; i < GAP; i++) exp_q.push_back('0);
  endtask

  task automatic run_burst(input logic [7:0] gn, input int push_at,
                           input logic [127:0] pd, input logic pl);
    logic [127:0] got[$];
    logic         last_busy;
    int           n;
    last_busy   = 1'b1;
    gain        = gn;
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    check("busy_rise", 128'(busy), 128'(1));
    check("underrun_clear", 128'(underrun), 128'(0));
    tick();
    n = 0;
    while (dac_valid === 1'b1 && n < 200) begin
      got.push_back(dac_data);
      last_busy = busy;
      if (n == push_at) begin
        s_if.s_data  = pd;
        s_if.s_last  = pl;
        s_if.s_valid = 1'b1;
      end
      tick();
      n++;
    end
    check("burst_len", 128'(n), 128'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("burst_word[%0d]", i), got[i], exp_q[i]);
    check("busy_fall", 128'(last_busy), 128'(0));
    check("idle_data", dac_data, 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn       = 1'b0;
    burst_start  = 1'b0;
    gain         = '0;
    s_if.s_data  = '0;
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;

    // Reset state
    repeat (5) tick();
    check("rst_dac_data", dac_data, 128'(0));
    check("rst_dac_valid", 128'(dac_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_underrun", 128'(underrun), 128'(0));
    resetn = 1'b1;
    tick();
    check("ready_after_reset", 128'(s_if.s_ready), 128'(1));

    // Nominal burst, unity gain
    w0 = {8{16'd1000}};
    push_word(w0, 1'b0);
    push_word(w0, 1'b0);
    push_word(w0, 1'b1);
    build_expected(8'd64);
    check("nominal_len_model", 128'(exp_q.size()), 128'(PRE + 3 + GAP));
    run_burst(8'd64, -1, '0, 1'b0);

    // Saturation at gain 128
    w0 = rand_word();
    w0[15:0]  = 16'(20000);
    w0[31:16] = 16'(-20000);
    push_word(w0, 1'b1);
    build_expected(8'd128);
    run_burst(8'd128, -1, '0, 1'b0);

    // Floor rounding at gain 32
    w0 = rand_word();
    w0[15:0] = 16'(-3);
    push_word(w0, 1'b1);
    build_expected(8'd32);
    run_burst(8'd32, -1, '0, 1'b0);

    // Zero gain
    push_word(rand_word(), 1'b1);
    build_expected(8'd0);
    run_burst(8'd0, -1, '0, 1'b0);

    // Randomized bursts
    for (int b = 0; b < 4; b++) begin
      int len;
      len = $urandom_range(1, 5);
      g   = 8'($urandom_range(0, 255));
      for (int i = 0; i < len; i++) push_word(rand_word(), i == len - 1);
      build_expected(g);
      run_burst(g, -1, '0, 1'b0);
    end

    // Underrun: one word without last, the closing word arrives late
    w1 = rand_word();
    w2 = rand_word();
    g  = 8'($urandom_range(1, 255));
    push_word(w1, 1'b0);
    mq.delete();
    exp_q.delete();
    for (int i = 0; i < PRE; i++) exp_q.push_back(pre_word());
    exp_q.push_back(scale_ref(w1, g));
    for (int i = 0; i < 5; i++) exp_q.push_back('0);
    exp_q.push_back(scale_ref(w2, g));
    for (int i = 0; i < GAP; i++) exp_q.push_back('0);
    run_burst(g, PRE + 4, w2, 1'b1);
    check("underrun_set", 128'(underrun), 128'(1));
    repeat (3) tick();
    check("underrun_sticky", 128'(underrun), 128'(1));

    // Full FIFO: 17th word held until the first pop
    for (int i = 0; i < 16; i++) push_word(rand_word(), 1'b0);
    check("full_ready_low", 128'(s_if.s_ready), 128'(0));
    w0 = rand_word();
    s_if.s_data  = w0;
    s_if.s_last  = 1'b1;
    s_if.s_valid = 1'b1;
    mq.push_back({1'b1, w0});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold", 128'(s_if.s_ready), 128'(0));
    end
    g = 8'($urandom_range(0, 255));
    build_expected(g);
    run_burst(g, -1, '0, 1'b0);
    check("full_drained_ready", 128'(s_if.s_ready), 128'(1));

    // Reset during the second payload word
    w0 = rand_word();
    w1 = rand_word();
    w2 = rand_word();
    push_word(w0, 1'b0);
    push_word(w1, 1'b0);
    push_word(w2, 1'b1);
    mq.delete();
    gain        = 8'd64;
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    tick();
    repeat (PRE + 1) tick();
    check("mid_second_word", dac_data, scale_ref(w1, 8'd64));
    resetn = 1'b0;
    tick();
    check("mid_rst_data", dac_data, 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_valid", 128'(dac_valid), 128'(0));
    resetn = 1'b1;
    tick();
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    tick();
    for (int i = 0; i < PRE + 3; i++) begin
      check($sformatf("post_rst_word[%0d]", i), dac_data, (i < PRE) ? pre_word() : 128'(0));
      check($sformatf("post_rst_valid[%0d]", i), 128'(dac_valid), 128'(1));
      tick();
    end
    check("post_rst_underrun", 128'(underrun), 128'(1));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check("final_idle_busy", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_burst_core.md
# tx_burst_core

Transmit-side burst engine, the counterpart of the receive core. It accepts packed 8-lane, 16-bit baseband words from the processing system over a valid/ready stream and buffers them in a small FIFO. On command it emits one burst onto the 128-bit DAC bus: optional preamble, then gain-scaled payload, then a zero guard gap. It sits between the PS/DMA sample source and the RF-DAC tile data input, in the same full-rate clock domain the receive chain uses.

## Interface
- FIFO_DEPTH, 16: payload FIFO depth in 128-bit words; power of two, ≥4
- PREAMBLE_WORDS, 4: preamble length in DAC words; ≥1
- GAP_WORDS, 2: zero guard words after payload; ≥1
- clock  in  1: DAC-rate fabric clock, all logic rising-edge
- resetn  in  1: synchronous, active-low reset
- s_data  in  128: 8 signed 16-bit samples, lane k at [16k+15:16k], lane 0 earliest
- s_valid  in  1: s_data/s_last valid
- s_last  in  1: word is final payload word of a burst
- s_ready  out  1: FIFO can accept; transfer when s_valid && s_ready
- burst_start  in  1: single-cycle start request
- gain  in  8: unsigned gain, 64 = unity; latched at accepted burst_start
- dac_data  out  128: DAC samples, same lane packing
- dac_valid  out  1: high while dac_data carries a burst (preamble/payload/gap)
- busy  out  1: state ≠ IDLE
- underrun  out  1: sticky, FIFO empty during PAYLOAD

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, GAP.
- IDLE: burst_start accepted only here. Outside IDLE it is ignored. Acceptance latches gain, clears underrun, and moves to PREAMBLE (or PAYLOAD without macro).
- PREAMBLE: PREAMBLE_WORDS cycles. Word pattern: even lanes +16384, odd lanes −16384 (fs/2 tone). The pattern is not gain-scaled. Then PAYLOAD.
- PAYLOAD: pop one FIFO word per cycle while non-empty, scale and emit it.
  - FIFO empty: emit zeros, set underrun, remain in PAYLOAD.
  - Popped word with last flag: next state GAP.
- GAP: GAP_WORDS zero words, then IDLE.
- Scaling per lane: p = sample × {1'b0, gain_latched}, 25-bit signed. r = p >>> 6 (arithmetic, floor). Saturate r to [−32768, 32767].
- FIFO stores 129 bits (data + last). s_ready = !full.
  - Push and pop in the same cycle are both honoured.
  - Pushes are accepted in any state, including during a burst.
- Reset, including mid-burst: state IDLE, FIFO flushed, gain_latched 0.

## Timing
- Reset values: dac_data 0, dac_valid 0, busy 0, underrun 0. s_ready is 1 from the first cycle after reset is released.
- All outputs registered. dac_data reflects the state/pop of the previous cycle, so latency is 1 cycle.
- burst_start at cycle 0 gives: busy=1 at cycle 1; first preamble word on dac_data at cycle 2.
- Burst length on dac_valid = PREAMBLE_WORDS + payload words + underrun words + GAP_WORDS. dac_valid is contiguous.
- busy falls in the cycle the last gap word appears on dac_data.
- In IDLE, dac_data = 0 and dac_valid = 0.
- FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.

## Configuration
- TX_BURST_PREAMBLE_EN defined: PREAMBLE state and pattern generator present.
- Not defined: the PREAMBLE state is removed, accepted burst_start goes directly to PAYLOAD, and PREAMBLE_WORDS is ignored. First payload word appears at cycle 2 after burst_start.

## Structure
- tx_burst_pkg: SAMPLE_W=16, LANES=8, UNITY_SHIFT=6, PREAMBLE_POS=16384, state enum, and a sat16 saturation function.
- Sub-module tx_sample_fifo: synchronous FIFO, parameterised width/depth, first-word-fall-through, with full and empty outputs.

## Test plan
- Reset: hold resetn=0 for 5 cycles → all outputs 0; s_ready=1 after release.
- Nominal burst: push 3 words (all lanes 1000, last on third), gain=64, burst_start → 4 preamble words ±16384, then three words of 1000, then 2 zero words, with dac_valid high for 9 cycles; busy drops.
- Arithmetic (one lane value per check):
  - gain=128: 20000 → 32767, −20000 → −32768.
  - gain=32: −3 → −2.
  - gain=0: any value → 0.
- Underrun: push 1 word without last, start burst, wait 5 cycles, then push 1 word with last → 5 zero words with underrun=1, then the pushed word, then the gap. underrun stays 1 until the next burst_start.
- Full FIFO: in IDLE push 17 words back-to-back → s_ready low after the 16th; the 17th is held until one pop, then accepted.
- Reset mid-payload: assert resetn=0 during the second payload word → next cycle dac_data=0, busy=0; a subsequent burst_start with an empty FIFO produces preamble then underrun zeros.
